// File: rtl/punc_control.sv
// PUnC LC3 control unit: sequences fetch/decode/execute state codes for the
// datapath and reports halt, sticky illegal-opcode and retired-instruction count.
module punc_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      instruction,
    output logic [4:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [4:0] S_FETCH   = 5'd0;
    localparam logic [4:0] S_DECODE  = 5'd1;
    localparam logic [4:0] S_ADD_REG = 5'd2;
    localparam logic [4:0] S_ADD_IMM = 5'd3;
    localparam logic [4:0] S_AND_REG = 5'd4;
    localparam logic [4:0] S_AND_IMM = 5'd5;
    localparam logic [4:0] S_BR      = 5'd6;
    localparam logic [4:0] S_JMP     = 5'd7;
    localparam logic [4:0] S_JSR1    = 5'd8;
    localparam logic [4:0] S_JSR2    = 5'd9;
    localparam logic [4:0] S_JSRR1   = 5'd10;
    localparam logic [4:0] S_JSRR2   = 5'd11;
    localparam logic [4:0] S_LD      = 5'd12;
    localparam logic [4:0] S_LDI1    = 5'd13;
    localparam logic [4:0] S_LDI2    = 5'd14;
    localparam logic [4:0] S_LDR     = 5'd15;
    localparam logic [4:0] S_LEA     = 5'd16;
    localparam logic [4:0] S_NOT     = 5'd17;
    localparam logic [4:0] S_RET     = 5'd18;
    localparam logic [4:0] S_ST      = 5'd19;
    localparam logic [4:0] S_STI1    = 5'd20;
    localparam logic [4:0] S_STI2    = 5'd21;
    localparam logic [4:0] S_STR     = 5'd22;
    localparam logic [4:0] S_HALT    = 5'd23;

    logic [4:0] nxt;
    logic       set_ill;
    logic       is_final;
    logic       count;

    always_comb begin
        nxt      = S_FETCH;
        set_ill  = 1'b0;
        is_final = 1'b0;
        case (state)
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                case (instruction[15:12])
                    4'b0001: nxt = instruction[5] ? S_ADD_IMM : S_ADD_REG;
                    4'b0101: nxt = instruction[5] ? S_AND_IMM : S_AND_REG;
                    4'b0000: nxt = S_BR;
                    4'b1100: nxt = (instruction[8:6] == 3'b111) ? S_RET : S_JMP;
                    4'b0100: nxt = instruction[11] ? S_JSR1 : S_JSRR1;
                    4'b0010: nxt = S_LD;
                    4'b1010: nxt = S_LDI1;
                    4'b0110: nxt = S_LDR;
                    4'b1110: nxt = S_LEA;
                    4'b1001: nxt = S_NOT;
                    4'b0011: nxt = S_ST;
                    4'b1011: nxt = S_STI1;
                    4'b0111: nxt = S_STR;
                    4'b1111: nxt = S_HALT;
                    default: set_ill = 1'b1;    // 1000 / 1101: reserved
                endcase
            end
            S_JSR1:  nxt = S_JSR2;
            S_JSRR1: nxt = S_JSRR2;
            S_LDI1:  nxt = S_LDI2;
            S_STI1:  nxt = S_STI2;
            S_HALT:  nxt = S_HALT;
            S_ADD_REG, S_ADD_IMM, S_AND_REG, S_AND_IMM, S_BR, S_JMP, S_JSR2,
            S_JSRR2, S_LD, S_LDI2, S_LDR, S_LEA, S_NOT, S_RET, S_ST, S_STI2,
            S_STR:   is_final = 1'b1;
            default: set_ill = 1'b1;            // unreachable codes 24-31 recover to fetch
        endcase
    end

    // TRAP retires on entry to HALT since HALT never returns to fetch
    assign count = (is_final && nxt == S_FETCH) || (state == S_DECODE && nxt == S_HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_FETCH;
            halted  <= 1'b0;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state  <= nxt;
            halted <= (nxt == S_HALT);
            if (set_ill)
                illegal <= 1'b1;
            if (count && retired != {CNT_W{1'b1}})
                retired <= retired + 1'b1;
        end
    end

endmodule

// File: tb/tb_punc_control.sv
// Self-checking bench for punc_control: directed program plus random opcodes
// against an opcode-level reference model; a 2-bit-counter instance covers saturation.
module tb_punc_control;

    logic        clk;
    logic        rst;
    logic [15:0] instruction;
    logic [4:0]  state, state2;
    logic        halted, halted2;
    logic        illegal, illegal2;
    logic [15:0] retired;
    logic [1:0]  retired2;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_ret  = 0;
    int m_ret2 = 0;
    logic m_ill = 1'b0;

    punc_control #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .instruction(instruction),
        .state(state), .halted(halted), .illegal(illegal), .retired(retired)
    );

    punc_control #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .instruction(instruction),
        .state(state2), .halted(halted2), .illegal(illegal2), .retired(retired2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // first execute state for an instruction word, 0 for reserved opcodes
    function automatic int first_exec(input logic [15:0] ir);
        case (ir[15:12])
            4'h1: return ir[5] ? 3 : 2;
            4'h5: return ir[5] ? 5 : 4;
            4'h0: return 6;
            4'hC: return (ir[8:6] == 3'd7) ? 18 : 7;
            4'h4: return ir[11] ? 8 : 10;
            4'h2: return 12;
            4'hA: return 13;
            4'h6: return 15;
            4'hE: return 16;
            4'h9: return 17;
            4'h3: return 19;
            4'hB: return 20;
            4'h7: return 22;
            4'hF: return 23;
            default: return 0;
        endcase
    endfunction

    function automatic bit two_step(input int s);
        return (s == 8 || s == 10 || s == 13 || s == 20);
    endfunction

    task automatic retire_model();
        if (m_ret < 65535) m_ret++;
        if (m_ret2 < 3) m_ret2++;
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, ".retired"}, retired, m_ret);
        chk({tag, ".retired2"}, retired2, m_ret2);
        chk({tag, ".illegal"}, illegal, m_ill);
        chk({tag, ".illegal2"}, illegal2, m_ill);
    endtask

    // Runs one instruction starting in fetch; returns its cycle count.
    task automatic run_instr(input logic [15:0] ir, input string tag, output int cyc);
        int e;
        e = first_exec(ir);
        chk({tag, ".fetch"}, state, 0);
        instruction = ir;
        @(posedge clk); #1;
        chk({tag, ".decode"}, state, 1);
        @(posedge clk); #1;
        instruction = 16'($urandom);   // must be ignored outside decode
        chk({tag, ".exec1"}, state, e);
        chk({tag, ".halted"}, halted, (e == 23));
        cyc = 2;
        if (e == 0) begin
            m_ill = 1'b1;
            chk_counters(tag);
            return;
        end
        if (e == 23) begin
            retire_model();
            chk_counters(tag);
            return;
        end
        if (two_step(e)) begin
            @(posedge clk); #1;
            chk({tag, ".exec2"}, state, e + 1);
            cyc++;
        end
        @(posedge clk); #1;
        cyc++;
        retire_model();
        chk({tag, ".back"}, state, 0);
        chk_counters(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".state"}, state, 0);
        chk({tag, ".halted"}, halted, 0);
        chk({tag, ".illegal"}, illegal, 0);
        chk({tag, ".retired"}, retired, 0);
        chk({tag, ".retired2"}, retired2, 0);
    endtask

    initial begin
        int cyc;
        logic [15:0] ir;
        rst = 1'b1;
        instruction = 16'h12A3;
        #3 rst = 1'b0;
        #1 check_zero("reset");
        @(negedge clk); rst = 1'b1;

        run_instr(16'h12A3, "add_imm", cyc);
        chk("add_imm.cycles", cyc, 3);

        run_instr(16'h1042, "add_reg", cyc);
        run_instr(16'h5020, "and_imm", cyc);
        run_instr(16'hC1C0, "ret", cyc);
        chk("prog.retired4", retired, 4);

        run_instr(16'hC080, "jmp", cyc);
        run_instr(16'h4801, "jsr", cyc);
        chk("jsr.cycles", cyc, 4);
        run_instr(16'h4080, "jsrr", cyc);
        chk("jsrr.cycles", cyc, 4);
        run_instr(16'hA001, "ldi", cyc);
        chk("ldi.cycles", cyc, 4);
        run_instr(16'hB001, "sti", cyc);
        chk("sti.cycles", cyc, 4);

        run_instr(16'h8000, "ill8", cyc);
        chk("ill8.cycles", cyc, 2);
        run_instr(16'h0E01, "br", cyc);
        run_instr(16'hD000, "illD", cyc);

        // random non-TRAP instructions, including reserved opcodes
        for (int i = 0; i < 60; i++) begin
            ir = 16'($urandom);
            if (ir[15:12] == 4'hF) ir[15:12] = 4'h8;
            run_instr(ir, "rand", cyc);
        end

        // reset in the second step of STI abandons it without a count
        instruction = 16'hB001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("sti_rst.s1", state, 20);
        @(posedge clk); #1;
        chk("sti_rst.s2", state, 21);
        #2 rst = 1'b0;
        #1 check_zero("sti_rst");
        @(negedge clk); rst = 1'b1;
        m_ret = 0; m_ret2 = 0; m_ill = 1'b0;

        run_instr(16'hF025, "trap", cyc);
        for (int i = 0; i < 20; i++) begin
            instruction = 16'($urandom);
            @(posedge clk); #1;
            chk("halt.state", state, 23);
            chk("halt.halted", halted, 1);
        end
        chk_counters("halt");
        #2 rst = 1'b0;
        #1 check_zero("halt_rst");
        @(negedge clk); rst = 1'b1;
        m_ret = 0; m_ret2 = 0; m_ill = 1'b0;

        // 2-bit counter saturates at 3 after five ADDs
        for (int i = 0; i < 5; i++) run_instr(16'h1042, "sat", cyc);
        chk("sat.final2", retired2, 3);
        chk("sat.final16", retired, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
